// File: rtl/arith_divider_pkg.sv
// Shared constants, opcodes and FSM state type for the execute-stage divider.
// WORD_SIZE is the machine word width used across the execute stage.
package arith_divider_pkg;

  localparam int WORD_SIZE = 19;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SHL = 4'd5,
    OP_SHR = 4'd6,
    OP_MUL = 4'd7,
    OP_DIV = 4'd8
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/arith_div_step.sv
// One restoring-division iteration: shift {rem, q} left by one, then keep the
// trial subtraction only when it does not go negative.
module arith_div_step #(
  parameter int WORD_SIZE = arith_divider_pkg::WORD_SIZE
) (
  input  logic [WORD_SIZE:0]   rem,
  input  logic [WORD_SIZE-1:0] q,
  input  logic [WORD_SIZE-1:0] divisor_mag,
  output logic [WORD_SIZE:0]   rem_next,
  output logic [WORD_SIZE-1:0] q_next
);

  logic [WORD_SIZE+1:0] rem_sh_s;
  logic [WORD_SIZE+1:0] trial_s;
  logic [WORD_SIZE-1:0] q_sh_s;

  assign rem_sh_s = {rem, q[WORD_SIZE-1]};
  assign q_sh_s   = {q[WORD_SIZE-2:0], 1'b0};
  // One guard bit above the shifted remainder keeps the borrow visible.
  assign trial_s  = rem_sh_s - {2'b00, divisor_mag};

  // Restore or commit the trial subtraction.
  always_comb begin
    rem_next = rem_sh_s[WORD_SIZE:0];
    q_next   = q_sh_s;
    if (trial_s[WORD_SIZE+1] == 1'b0) begin
      rem_next = trial_s[WORD_SIZE:0];
      q_next   = {q_sh_s[WORD_SIZE-1:1], 1'b1};
    end else begin
      rem_next = rem_sh_s[WORD_SIZE:0];
      q_next   = q_sh_s;
    end
  end

endmodule

// File: rtl/arith_divider.sv
// Sequential signed/unsigned restoring divider, one quotient bit per cycle,
// with valid/ready handshakes on both the request and the result side.
module arith_divider
  import arith_divider_pkg::*;
#(
  parameter int WORD_SIZE = arith_divider_pkg::WORD_SIZE,
  parameter int CNT_W     = $clog2(WORD_SIZE + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 signed_mode,
  input  logic [WORD_SIZE-1:0] dividend,
  input  logic [WORD_SIZE-1:0] divisor,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] quotient,
  output logic [WORD_SIZE-1:0] remainder,
  output logic                 div_by_zero,
  output logic                 overflow
);

  localparam logic [WORD_SIZE-1:0] ZERO_W    = {WORD_SIZE{1'b0}};
  localparam logic [WORD_SIZE-1:0] ONES_W    = {WORD_SIZE{1'b1}};
  localparam logic [WORD_SIZE-1:0] ONE_W     = {{(WORD_SIZE-1){1'b0}}, 1'b1};
  localparam logic [WORD_SIZE-1:0] MIN_NEG_W = {1'b1, {(WORD_SIZE-1){1'b0}}};

  function automatic logic [WORD_SIZE-1:0] neg_f(input logic [WORD_SIZE-1:0] x);
    return ~x + ONE_W;
  endfunction

  // The most negative value maps onto itself, which is its correct unsigned magnitude.
  function automatic logic [WORD_SIZE-1:0] mag_f(input logic [WORD_SIZE-1:0] x,
                                                 input logic is_signed);
    if (is_signed && x[WORD_SIZE-1]) begin
      return neg_f(x);
    end else begin
      return x;
    end
  endfunction

  div_state_t           state_r, state_nx_s;
  logic [CNT_W-1:0]     count_r;
  logic [WORD_SIZE:0]   rem_r, rem_next_s;
  logic [WORD_SIZE-1:0] q_r, q_next_s;
  logic [WORD_SIZE-1:0] dvs_mag_r;
  logic                 sign_q_r, sign_r_r, ovf_r;
  logic                 in_ready_r, out_valid_r;
  logic [WORD_SIZE-1:0] quotient_r, remainder_r;
  logic                 div_by_zero_r, overflow_r;
  logic                 load_s, step_s, fix_s, hs_s, dz_s;

  assign dz_s = (divisor == ZERO_W);

  arith_div_step #(.WORD_SIZE(WORD_SIZE)) u_step (
    .rem         (rem_r),
    .q           (q_r),
    .divisor_mag (dvs_mag_r),
    .rem_next    (rem_next_s),
    .q_next      (q_next_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid && in_ready_r) begin
          state_nx_s = dz_s ? DONE : CALC;
        end else begin
          state_nx_s = IDLE;
        end
      end
      CALC: begin
        if (count_r == CNT_W'(1)) begin
          state_nx_s = FIX;
        end else begin
          state_nx_s = CALC;
        end
      end
      FIX:  state_nx_s = DONE;
      DONE: begin
        if (out_ready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = DONE;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Per-state datapath strobes.
  always_comb begin
    load_s = 1'b0;
    step_s = 1'b0;
    fix_s  = 1'b0;
    hs_s   = 1'b0;
    case (state_r)
      IDLE:    load_s = in_valid && in_ready_r;
      CALC:    step_s = 1'b1;
      FIX:     fix_s  = 1'b1;
      DONE:    hs_s   = out_ready;
      default: load_s = 1'b0;
    endcase
  end

  // Handshake flags; in_ready is only raised on an edge that lands in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      in_ready_r <= (state_nx_s == IDLE);
      if (fix_s || (load_s && dz_s)) begin
        out_valid_r <= 1'b1;
      end else if (hs_s) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

  // Operand latches, iteration registers and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r       <= {CNT_W{1'b0}};
      rem_r         <= {(WORD_SIZE+1){1'b0}};
      q_r           <= ZERO_W;
      dvs_mag_r     <= ZERO_W;
      sign_q_r      <= 1'b0;
      sign_r_r      <= 1'b0;
      ovf_r         <= 1'b0;
      quotient_r    <= ZERO_W;
      remainder_r   <= ZERO_W;
      div_by_zero_r <= 1'b0;
      overflow_r    <= 1'b0;
    end else if (load_s) begin
      sign_q_r  <= signed_mode & (dividend[WORD_SIZE-1] ^ divisor[WORD_SIZE-1]);
      sign_r_r  <= signed_mode & dividend[WORD_SIZE-1];
      ovf_r     <= signed_mode && (dividend == MIN_NEG_W) && (divisor == ONES_W);
      dvs_mag_r <= mag_f(divisor, signed_mode);
      q_r       <= mag_f(dividend, signed_mode);
      rem_r     <= {(WORD_SIZE+1){1'b0}};
      count_r   <= CNT_W'(WORD_SIZE);
      if (dz_s) begin
        quotient_r    <= ONES_W;
        remainder_r   <= dividend;
        div_by_zero_r <= 1'b1;
        overflow_r    <= 1'b0;
      end else begin
        quotient_r    <= quotient_r;
        remainder_r   <= remainder_r;
        div_by_zero_r <= div_by_zero_r;
        overflow_r    <= overflow_r;
      end
    end else if (step_s) begin
      rem_r   <= rem_next_s;
      q_r     <= q_next_s;
      count_r <= count_r - CNT_W'(1);
    end else if (fix_s) begin
      quotient_r    <= sign_q_r ? neg_f(q_r) : q_r;
      remainder_r   <= sign_r_r ? neg_f(rem_r[WORD_SIZE-1:0]) : rem_r[WORD_SIZE-1:0];
      div_by_zero_r <= 1'b0;
      overflow_r    <= ovf_r;
    end else begin
      count_r <= count_r;
    end
  end

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign quotient    = quotient_r;
  assign remainder   = remainder_r;
  assign div_by_zero = div_by_zero_r;
  assign overflow    = overflow_r;

endmodule

// File: tb/tb_arith_divider.sv
// Self-checking bench for arith_divider: directed spec cases, handshake
// scenarios, reset mid-operation and randomized traffic against an integer model.
module tb_arith_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        signed_mode = 1'b0;
  logic [18:0] dividend = 19'd0;
  logic [18:0] divisor = 19'd0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, div_by_zero, overflow;
  logic [18:0] quotient, remainder;

  int checks = 0;
  int errors = 0;

  arith_divider dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .signed_mode (signed_mode),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // Reference: plain integer division, truncating toward zero.
  task automatic ref_div(input logic sm, input logic [18:0] a, input logic [18:0] b,
                         output logic [18:0] q, output logic [18:0] r,
                         output logic dz, output logic ov);
    longint sa, sb, lq, lr;
    if (b == 19'd0) begin
      q = 19'h7FFFF; r = a; dz = 1'b1; ov = 1'b0;
    end else begin
      sa = sm ? longint'($signed(a)) : longint'(a);
      sb = sm ? longint'($signed(b)) : longint'(b);
      lq = sa / sb;
      lr = sa % sb;
      q  = lq[18:0];
      r  = lr[18:0];
      dz = 1'b0;
      ov = sm && (sa == -64'sd262144) && (sb == -64'sd1);
    end
  endtask

  // Issue one request and wait for out_valid; lat counts the accept edge as 1.
  task automatic issue(input logic sm, input logic [18:0] a, input logic [18:0] b,
                       input bit scramble, output int lat);
    int w;
    @(negedge clk);
    signed_mode = sm; dividend = a; divisor = b; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_wait in_ready=%b expected 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      if (scramble) begin
        dividend = 19'($urandom); divisor = 19'($urandom); signed_mode = 1'($urandom);
      end
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({in_ready, out_valid, div_by_zero, overflow} !== 4'b0000 ||
        quotient !== 19'd0 || remainder !== 19'd0) begin
      errors++;
      $display("FAIL reset_values rdy=%b vld=%b dz=%b ov=%b q=%h r=%h expected all 0",
               in_ready, out_valid, div_by_zero, overflow, quotient, remainder);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got %b expected 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic        v_sm [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [18:0] v_a  [8] = '{19'd100, 19'h7FF9C, 19'd100, 19'h12345, 19'h40000, 19'h7FFFF, 19'h40000, 19'h40000};
    logic [18:0] v_b  [8] = '{19'd7, 19'd7, 19'h7FFF9, 19'd0, 19'h7FFFF, 19'd1, 19'd0, 19'h7FFFF};
    logic [18:0] e_q  [8] = '{19'd14, 19'h7FFF2, 19'h7FFF2, 19'h7FFFF, 19'h40000, 19'h7FFFF, 19'h7FFFF, 19'd0};
    logic [18:0] e_r  [8] = '{19'd2, 19'h7FFFE, 19'd2, 19'h12345, 19'd0, 19'd0, 19'h40000, 19'h40000};
    logic        e_dz [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        e_ov [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    int lat, e_lat;
    for (int i = 0; i < 8; i++) begin
      issue(v_sm[i], v_a[i], v_b[i], 1'b0, lat);
      e_lat = e_dz[i] ? 1 : 21;
      checks++;
      if (lat !== e_lat) begin
        errors++; $display("FAIL dir%0d_latency got %0d expected %0d", i, lat, e_lat);
      end
      checks++;
      if (quotient !== e_q[i] || remainder !== e_r[i]) begin
        errors++; $display("FAIL dir%0d_result q=%h r=%h expected q=%h r=%h", i, quotient, remainder, e_q[i], e_r[i]);
      end
      checks++;
      if (div_by_zero !== e_dz[i] || overflow !== e_ov[i]) begin
        errors++; $display("FAIL dir%0d_flags dz=%b ov=%b expected dz=%b ov=%b", i, div_by_zero, overflow, e_dz[i], e_ov[i]);
      end
      handshake();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL dir%0d_valid_drop got %b expected 0", i, out_valid);
      end
    end
  endtask

  task automatic test_stall();
    int lat;
    issue(1'b0, 19'd1000, 19'd3, 1'b0, lat);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || quotient !== 19'd333 || remainder !== 19'd1) begin
        errors++; $display("FAIL stall_hold c%0d vld=%b q=%h r=%h expected 1 14d 1", c, out_valid, quotient, remainder);
      end
    end
    handshake();
    checks++;
    if (out_valid !== 1'b0 || quotient !== 19'd333 || remainder !== 19'd1) begin
      errors++; $display("FAIL stall_after vld=%b q=%h r=%h expected 0 14d 1", out_valid, quotient, remainder);
    end
  endtask

  task automatic test_operand_change();
    int lat;
    logic [18:0] eq, er;
    logic edz, eov;
    ref_div(1'b1, 19'h7FC18, 19'd17, eq, er, edz, eov);
    issue(1'b1, 19'h7FC18, 19'd17, 1'b1, lat);
    checks++;
    if (lat !== 21 || quotient !== eq || remainder !== er || div_by_zero !== 1'b0) begin
      errors++; $display("FAIL operand_change lat=%0d q=%h r=%h expected 21 q=%h r=%h", lat, quotient, remainder, eq, er);
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    int acc_c [2];
    int acc_n = 0;
    int ov_cnt = 0;
    int hs_c = -1;
    @(negedge clk);
    signed_mode = 1'b0; dividend = 19'd200; divisor = 19'd9;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 80; c++) begin
      if (c > 0) @(negedge clk);
      if (acc_n == 2) in_valid = 1'b0;
      if (out_valid && acc_n == 1) begin
        ov_cnt++;
        hs_c = c;
      end
      if (in_ready && in_valid && acc_n < 2) begin
        acc_c[acc_n] = c;
        acc_n++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (acc_n !== 2) begin
      errors++; $display("FAIL b2b_accepts got %0d expected 2", acc_n);
    end else begin
      checks++;
      if (ov_cnt !== 1 || hs_c - acc_c[0] !== 21) begin
        errors++; $display("FAIL b2b_first_result valid_cycles=%0d at=%0d expected 1 at 21", ov_cnt, hs_c - acc_c[0]);
      end
      checks++;
      if (acc_c[1] !== hs_c + 1) begin
        errors++; $display("FAIL b2b_second_accept at=%0d expected %0d", acc_c[1], hs_c + 1);
      end
    end
    checks++;
    if (quotient !== 19'd22 || remainder !== 19'd2 || out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_final q=%h r=%h vld=%b expected 16 2 0", quotient, remainder, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int lat, w;
    @(negedge clk);
    signed_mode = 1'b0; dividend = 19'd100; divisor = 19'd7; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL midreset_async vld=%b rdy=%b expected 0 0", out_valid, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_release rdy=%b vld=%b expected 1 0", in_ready, out_valid);
    end
    issue(1'b0, 19'd50, 19'd5, 1'b0, lat);
    checks++;
    if (lat !== 21 || quotient !== 19'd10 || remainder !== 19'd0) begin
      errors++; $display("FAIL midreset_next lat=%0d q=%h r=%h expected 21 a 0", lat, quotient, remainder);
    end
    handshake();
  endtask

  task automatic test_random();
    int lat;
    logic sm;
    logic [18:0] a, b, eq, er;
    logic edz, eov;
    for (int i = 0; i < 40; i++) begin
      sm = 1'($urandom);
      a  = ($urandom_range(0, 7) == 0) ? 19'h40000 : 19'($urandom);
      case ($urandom_range(0, 9))
        0:       b = 19'd0;
        1:       b = 19'h7FFFF;
        2:       b = 19'($urandom_range(1, 20));
        default: b = 19'($urandom);
      endcase
      ref_div(sm, a, b, eq, er, edz, eov);
      issue(sm, a, b, 1'b0, lat);
      checks++;
      if (lat !== (edz ? 1 : 21)) begin
        errors++; $display("FAIL rnd%0d_latency got %0d expected %0d", i, lat, edz ? 1 : 21);
      end
      checks++;
      if (quotient !== eq || remainder !== er || div_by_zero !== edz || overflow !== eov) begin
        errors++;
        $display("FAIL rnd%0d_result sm=%b a=%h b=%h got q=%h r=%h dz=%b ov=%b expected q=%h r=%h dz=%b ov=%b",
                 i, sm, a, b, quotient, remainder, div_by_zero, overflow, eq, er, edz, eov);
      end
      handshake();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_operand_change();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/arith_divider.md
# arith_divider

Sequential 19-bit integer divider for the CPU execute stage. It computes quotient and remainder, signed or unsigned, by restoring division at one bit per cycle. The single-cycle arithmetic unit hands DIV operations to this block over a valid/ready handshake, and the result is returned over a second handshake. Operands are latched on acceptance, so the issuing side may change its inputs freely after the accept cycle.

## Interface
Parameters:
- WORD_SIZE, default constants::WORD_SIZE (19): operand and result width.
- CNT_W, default $clog2(WORD_SIZE+1) (5): width of the iteration counter.

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: request present.
- in_ready, output, 1: divider can accept a request; high only in IDLE.
- signed_mode, input, 1: 1 means two's-complement operands, 0 means unsigned.
- dividend, input, WORD_SIZE: numerator.
- divisor, input, WORD_SIZE: denominator.
- out_valid, output, 1: result present; held until out_ready.
- out_ready, input, 1: consumer takes the result.
- quotient, output, WORD_SIZE: result quotient.
- remainder, output, WORD_SIZE: result remainder; takes the dividend's sign in signed mode.
- div_by_zero, output, 1: divisor was 0.
- overflow, output, 1: signed (-2^18) / (-1).

## Operation
- States (div_state_t): IDLE, CALC, FIX, DONE.
- IDLE: in_ready=1.
  - On in_valid, the block latches signed_mode, the operand magnitudes, sign_q (dividend sign XOR divisor sign) and sign_r (dividend sign).
  - Magnitudes are the absolute values in signed mode and the raw values in unsigned mode. |0x40000| = 0x40000 is representable as unsigned.
- Divisor = 0 at accept:
  - Go directly to DONE.
  - quotient = 0x7FFFF (all ones), remainder = dividend unmodified, div_by_zero=1.
- Otherwise:
  - Clear the partial remainder (WORD_SIZE+1 bits).
  - Load the quotient shift register with the dividend magnitude.
  - Set count=WORD_SIZE and go to CALC.
- CALC, one step per cycle:
  - Shift {rem, q} left by 1.
  - trial = rem - divisor_mag. If trial is non-negative, rem=trial and q[0]=1; otherwise q[0]=0.
  - Decrement count. When count reaches 1 before the decrement, go to FIX.
- FIX:
  - In signed mode, negate q if sign_q, and negate rem if sign_r.
  - overflow = signed_mode && dividend==0x40000 && divisor==0x7FFFF. The wrapped quotient in that case is 0x40000 and the remainder is 0.
  - Go to DONE.
- DONE:
  - out_valid=1 and the outputs are stable.
  - On out_ready, go to IDLE. Results stay on the outputs until the next result is written; only out_valid drops.
- Arithmetic is modulo 2^WORD_SIZE. The trial subtract is WORD_SIZE+1 bits wide so that no borrow is lost.

## Timing
- Reset values:
  - in_ready=0 while rst_n is low, then 1 from the first clock edge in IDLE.
  - out_valid=0, quotient=0, remainder=0, div_by_zero=0, overflow=0, state=IDLE, count=0.
- Latency is counted from the accept edge (in_valid && in_ready) to the out_valid rising edge:
  - Normal case: WORD_SIZE+2 = 21 cycles (1 load, 19 CALC, 1 FIX).
  - Divide by zero: 1 cycle.
- Throughput: no back-to-back acceptance. A new request can be accepted at the earliest one cycle after the DONE handshake.
- Inputs seen while in_ready=0 are ignored, including in_valid in DONE during the out_ready cycle.
- If out_ready is held high on entry to DONE, out_valid is high for exactly 1 cycle.
- Reset asserted mid-CALC: the block is in IDLE immediately (asynchronously), out_valid=0, and the partial result is discarded.

## Structure
- Package constants: WORD_SIZE=19 (existing); add div_state_t as enum logic [1:0] {IDLE, CALC, FIX, DONE}.
- Package opcodes: the existing DIV opcode selects this unit. The opcode is not a port.
- Sub-module arith_div_step: combinational single iteration.
  - Inputs: rem, q, divisor_mag.
  - Outputs: rem_next, q_next.
  - Instantiated once; the top holds the FSM, counter, latches and sign fix-up.

## Test plan
- Unsigned 100 / 7 -> quotient=14, remainder=2, flags 0. out_valid rises exactly 21 cycles after accept.
- Signed -100 (0x7FF9C) / 7 -> quotient=-14 (0x7FFF2), remainder=-2 (0x7FFFE). Then 100 / -7 -> quotient=0x7FFF2, remainder=2.
- Divisor 0 with dividend 0x12345 -> div_by_zero=1, quotient=0x7FFFF, remainder=0x12345, out_valid 1 cycle after accept.
- Signed 0x40000 / 0x7FFFF -> overflow=1, quotient=0x40000, remainder=0. Unsigned 0x7FFFF / 1 -> quotient=0x7FFFF, remainder=0, overflow=0.
- Handshake checks:
  - Hold out_ready low for 10 cycles: out_valid and the results stay stable.
  - in_valid held high throughout: second acceptance only occurs after the handshake.
  - Operands changed during CALC: result unaffected.
- rst_n pulsed low at CALC cycle 8 -> out_valid=0 immediately, in_ready=1 after release. A subsequent 50 / 5 gives quotient=10, remainder=0.
